// File: rtl/display_pkg.sv
// Shared constants, state encoding and helpers for the 7-segment display scanner.
package display_pkg;

  localparam int unsigned NUM_DIGITS_DEFAULT = 4;
  localparam int unsigned DWELL_DEFAULT      = 4096;
  localparam int unsigned BLANK_DEFAULT      = 64;

  // Upper bound on digit count supported by nibble_sel.
  localparam int unsigned MAX_DIGITS = 16;
  localparam int unsigned MAX_VALUE_W = 4 * MAX_DIGITS;

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_ON    = 1'b1;

  typedef enum logic {
    StBlank = ST_BLANK,
    StOn    = ST_ON
  } scan_state_e;

  // Digit 0 is the most significant nibble of the value.
  function automatic logic [3:0] nibble_sel(input logic [MAX_VALUE_W-1:0] value,
                                            input int unsigned num_digits,
                                            input int unsigned idx);
    return value[(num_digits - 1 - idx) * 4 +: 4];
  endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Scan sequencer: BLANK/ON state machine, per-state phase counter and digit index.
module display_scan_timer
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = NUM_DIGITS_DEFAULT,
  parameter int unsigned DWELL_CYCLES = DWELL_DEFAULT,
  parameter int unsigned BLANK_CYCLES = BLANK_DEFAULT,
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  output scan_state_e       state,
  output logic [IDX_W-1:0]  idx,
  output logic              last_phase,
  output logic              enter_on,
  output logic              boundary
);

  localparam int unsigned PHASE_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  scan_state_e        state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  // Next-state: advance the phase, switch state at terminal count, step index on ON exit.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q + 1'b1;
    idx_d      = idx_q;
    last_phase = 1'b0;
    enter_on   = 1'b0;
    boundary   = 1'b0;
    unique case (state_q)
      StBlank: begin
        if (phase_q == PHASE_W'(BLANK_CYCLES - 1)) begin
          last_phase = 1'b1;
          enter_on   = 1'b1;
          state_d    = StOn;
          phase_d    = '0;
        end
      end
      StOn: begin
        if (phase_q == PHASE_W'(DWELL_CYCLES - 1)) begin
          last_phase = 1'b1;
          state_d    = StBlank;
          phase_d    = '0;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StBlank;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  assign state = state_q;
  assign idx   = idx_q;

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 4-digit 7-segment scanner with frame-synchronous value update
// and leading-zero blanking.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = NUM_DIGITS_DEFAULT,
  parameter int unsigned DWELL_CYCLES = DWELL_DEFAULT,
  parameter int unsigned BLANK_CYCLES = BLANK_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dots_in,
  input  logic                    load,
  input  logic                    lzb,
  output logic [3:0]              nibble,
  output logic                    dot,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VALUE_W = 4 * NUM_DIGITS;

  scan_state_e      state;
  logic [IDX_W-1:0] idx;
  logic             last_phase;
  logic             enter_on;
  logic             boundary;

  display_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .DWELL_CYCLES (DWELL_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .CLK        (CLK),
    .RST        (RST),
    .state      (state),
    .idx        (idx),
    .last_phase (last_phase),
    .enter_on   (enter_on),
    .boundary   (boundary)
  );

  logic [VALUE_W-1:0]    pending_q, pending_d;
  logic [NUM_DIGITS-1:0] pending_dots_q, pending_dots_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [VALUE_W-1:0]    active_q, active_d;
  logic [NUM_DIGITS-1:0] active_dots_q, active_dots_d;
  logic                  frame_start_q, frame_start_d;

  logic [3:0]            nibble_q, nibble_d;
  logic                  dot_q, dot_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;

  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;
  logic                  suppress;

  // Value staging: loads park in pending and are promoted at the frame boundary.
  // During the first cycle of a frame digit 0 has not been sampled yet, so a load
  // there still lands in the current frame.
  always_comb begin
    pending_d       = pending_q;
    pending_dots_d  = pending_dots_q;
    pending_valid_d = pending_valid_q;
    active_d        = active_q;
    active_dots_d   = active_dots_q;
    frame_start_d   = boundary;
    if (boundary) begin
      if (load) begin
        active_d        = value_in;
        active_dots_d   = dots_in;
        pending_valid_d = 1'b0;
      end else if (pending_valid_q) begin
        active_d        = pending_q;
        active_dots_d   = pending_dots_q;
        pending_valid_d = 1'b0;
      end
    end else if (load && frame_start_q) begin
      active_d        = value_in;
      active_dots_d   = dots_in;
      pending_valid_d = 1'b0;
    end else if (load) begin
      pending_d       = value_in;
      pending_dots_d  = dots_in;
      pending_valid_d = 1'b1;
    end
  end

  // Leading-zero map: digit i suppressible when digits 0..i are all zero (never the last).
  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_run = zero_run & (active_d[(NUM_DIGITS - 1 - i) * 4 +: 4] == 4'h0);
      if (i < NUM_DIGITS - 1) begin
        lead_zero[i] = zero_run;
      end
    end
  end

  assign suppress = lzb & lead_zero[idx];

  // Output next-state: latch digit data on ON entry, drop the select on ON exit.
  always_comb begin
    nibble_d    = nibble_q;
    dot_d       = dot_q;
    digit_sel_d = digit_sel_q;
    if (enter_on) begin
      nibble_d         = nibble_sel(MAX_VALUE_W'(active_d), NUM_DIGITS, 32'(idx));
      dot_d            = active_dots_d[idx] & ~suppress;
      digit_sel_d      = '0;
      digit_sel_d[idx] = ~suppress;
    end else if (last_phase && (state == StOn)) begin
      digit_sel_d = '0;
    end
  end

  // Registers with synchronous reset; pending data is discarded on reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_q       <= '0;
      pending_dots_q  <= '0;
      pending_valid_q <= 1'b0;
      active_q        <= '0;
      active_dots_q   <= '0;
      frame_start_q   <= 1'b0;
      nibble_q        <= '0;
      dot_q           <= 1'b0;
      digit_sel_q     <= '0;
    end else begin
      pending_q       <= pending_d;
      pending_dots_q  <= pending_dots_d;
      pending_valid_q <= pending_valid_d;
      active_q        <= active_d;
      active_dots_q   <= active_dots_d;
      frame_start_q   <= frame_start_d;
      nibble_q        <= nibble_d;
      dot_q           <= dot_d;
      digit_sel_q     <= digit_sel_d;
    end
  end

  assign nibble      = nibble_q;
  assign dot         = dot_q;
  assign digit_sel   = digit_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner (4 digits, dwell 8, blank 2).
module tb_display_scanner;

  localparam int unsigned ND    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned BL    = 2;
  localparam int unsigned SLOT  = DW + BL;
  localparam int unsigned FRAME = ND * SLOT;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] value_in;
  logic [3:0]  dots_in;
  logic        load;
  logic        lzb;
  logic [3:0]  nibble;
  logic        dot;
  logic [3:0]  digit_sel;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  display_scanner #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .value_in    (value_in),
    .dots_in     (dots_in),
    .load        (load),
    .lzb         (lzb),
    .nibble      (nibble),
    .dot         (dot),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Walk ncyc cycles of one frame from its first cycle, checking every output each
  // cycle against the expected displayed value; optionally pulse load at two offsets.
  task automatic run_frame(input string name, input logic [15:0] exp_val,
                           input logic [3:0] exp_dots, input logic exp_fs, input int ncyc,
                           input int ld0_k, input logic [15:0] ld0_val, input logic [3:0] ld0_dots,
                           input int ld1_k, input logic [15:0] ld1_val, input logic [3:0] ld1_dots);
    logic [3:0] supp;
    logic [3:0] sel_exp;
    logic       zr;
    int         i;
    int         p;
    zr   = 1'b1;
    supp = '0;
    for (int d = 0; d < ND; d++) begin
      zr = zr & (exp_val[(ND - 1 - d) * 4 +: 4] == 4'h0);
      if (d < ND - 1) supp[d] = zr & lzb;
    end
    for (int k = 0; k < ncyc; k++) begin
      i = k / SLOT;
      p = k % SLOT;
      check_val($sformatf("%s k=%0d frame_start", name, k), 32'(frame_start),
                32'((k == 0) ? exp_fs : 1'b0));
      check_val($sformatf("%s k=%0d onehot0", name, k), 32'($onehot0(digit_sel)), 32'd1);
      if (p < BL) begin
        check_val($sformatf("%s k=%0d blank_sel", name, k), 32'(digit_sel), 32'd0);
        if (i > 0) begin
          check_val($sformatf("%s k=%0d hold_nibble", name, k), 32'(nibble),
                    32'(exp_val[(ND - i) * 4 +: 4]));
          check_val($sformatf("%s k=%0d hold_dot", name, k), 32'(dot),
                    32'(exp_dots[i - 1] & ~supp[i - 1]));
        end
      end else begin
        sel_exp = supp[i] ? 4'b0000 : 4'(1 << i);
        check_val($sformatf("%s k=%0d sel", name, k), 32'(digit_sel), 32'(sel_exp));
        check_val($sformatf("%s k=%0d nibble", name, k), 32'(nibble),
                  32'(exp_val[(ND - 1 - i) * 4 +: 4]));
        check_val($sformatf("%s k=%0d dot", name, k), 32'(dot),
                  32'(exp_dots[i] & ~supp[i]));
      end
      load = 1'b0;
      if (k == ld0_k) begin
        load     = 1'b1;
        value_in = ld0_val;
        dots_in  = ld0_dots;
      end
      if (k == ld1_k) begin
        load     = 1'b1;
        value_in = ld1_val;
        dots_in  = ld1_dots;
      end
      @(negedge CLK);
    end
    load = 1'b0;
  endtask

  initial begin
    RST      = 1'b1;
    load     = 1'b0;
    lzb      = 1'b0;
    value_in = '0;
    dots_in  = '0;
    repeat (3) @(negedge CLK);
    check_val("reset digit_sel", 32'(digit_sel), 32'd0);
    check_val("reset nibble", 32'(nibble), 32'd0);
    check_val("reset dot", 32'(dot), 32'd0);
    check_val("reset frame_start", 32'(frame_start), 32'd0);
    RST = 1'b0;

    // First frame still shows zeros; the early load waits for the boundary.
    run_frame("f0", 16'h0000, 4'b0000, 1'b0, FRAME, 0, 16'h1234, 4'b0001, -1, 16'h0, 4'h0);
    // Two loads in one frame: only the last one is shown next frame.
    run_frame("f1", 16'h1234, 4'b0001, 1'b1, FRAME, 5, 16'hAAAA, 4'hF, 20, 16'h5555, 4'h0);
    run_frame("f2", 16'h5555, 4'b0000, 1'b1, FRAME, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    // Load in the frame_start cycle shows immediately; a later load waits.
    run_frame("f3", 16'hBEEF, 4'b1010, 1'b1, FRAME, 0, 16'hBEEF, 4'b1010, 30, 16'h0007, 4'hF);
    lzb = 1'b1;
    run_frame("f4_lzb0007", 16'h0007, 4'b1111, 1'b1, FRAME, 15, 16'h0000, 4'b1000,
              -1, 16'h0, 4'h0);
    run_frame("f5_lzb0000", 16'h0000, 4'b1000, 1'b1, FRAME, 15, 16'h0100, 4'b0001,
              -1, 16'h0, 4'h0);
    run_frame("f6_lzb0100", 16'h0100, 4'b0001, 1'b1, FRAME, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    lzb = 1'b0;
    // Stop inside digit 2 ON with a load pending, then reset.
    run_frame("f7_pre_rst", 16'h0100, 4'b0001, 1'b1, 25, 5, 16'h9876, 4'b0011,
              -1, 16'h0, 4'h0);
    check_val("pre_rst digit_sel", 32'(digit_sel), 32'h4);
    RST = 1'b1;
    @(negedge CLK);
    check_val("mid_rst digit_sel", 32'(digit_sel), 32'd0);
    check_val("mid_rst nibble", 32'(nibble), 32'd0);
    check_val("mid_rst dot", 32'(dot), 32'd0);
    check_val("mid_rst frame_start", 32'(frame_start), 32'd0);
    RST = 1'b0;
    run_frame("f8_post_rst", 16'h0000, 4'b0000, 1'b0, FRAME, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("f9_dropped", 16'h0000, 4'b0000, 1'b1, FRAME, 20, 16'h4321, 4'b1000,
              -1, 16'h0, 4'h0);
    run_frame("f10", 16'h4321, 4'b1000, 1'b1, FRAME, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("f11", 16'h4321, 4'b1000, 1'b1, FRAME, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
